// File: rtl/memoria_datos_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size codes,
// clear/operate FSM states and the alignment rule used by loads and stores.
package memoria_datos_pkg;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b11;

    typedef enum logic {
        LIMPIEZA  = 1'b0,
        OPERACION = 1'b1
    } estado_t;

    // Byte accesses are always aligned, halves need an even offset and
    // words (including the 2'b10 alias) need offset 00.
    function automatic logic acceso_desalineado(input logic [1:0] mascara,
                                                input logic [1:0] offset);
        logic res;
        case (mascara)
            MASK_BYTE: res = 1'b0;
            MASK_HALF: res = offset[0];
            default:   res = (offset != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/memoria_datos_alineador_carga.sv
// Load aligner: takes the addressed memory word and returns the selected
// byte/half/word shifted down to bit 0 with the upper bits zero-filled.
// Sign extension is left to the downstream signador.
module alineador_carga #(
    parameter int TAM_DATO = 32,
    parameter int TAM_MASK = 2
) (
    input  logic [TAM_DATO-1:0] palabra,
    input  logic [1:0]          offset,
    input  logic [TAM_MASK-1:0] mascara,
    output logic [TAM_DATO-1:0] dato
);
    import memoria_datos_pkg::*;

    logic [TAM_DATO-1:0] desplazada;

    // Shift the addressed lane down and keep only as many bytes as the access size.
    always_comb begin
        desplazada = palabra >> {offset, 3'b000};
        case (mascara)
            MASK_BYTE: dato = {{(TAM_DATO-8){1'b0}},  desplazada[7:0]};
            MASK_HALF: dato = {{(TAM_DATO-16){1'b0}}, desplazada[15:0]};
            default:   dato = palabra;
        endcase
    end

endmodule

// File: rtl/memoria_datos.sv
// MEM-stage data memory: word-organised RAM with byte/half/word stores,
// one-cycle right-aligned loads and a debug read port. After reset an FSM
// walks the whole array writing zeros before accesses are accepted.
module memoria_datos #(
    parameter int TAM_DATO      = 32,
    parameter int TAM_DIREC     = 32,
    parameter int TAM_MASK      = 2,
    parameter int CANT_PALABRAS = 32,
    localparam int IDX          = $clog2(CANT_PALABRAS)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_habilitado,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [TAM_MASK-1:0]  i_mascara,
    input  logic                 i_is_unsigned,
    input  logic [TAM_DIREC-1:0] i_direccion,
    input  logic [TAM_DATO-1:0]  i_dato_escritura,
    input  logic [IDX-1:0]       i_debug_direccion,
    output logic [TAM_DATO-1:0]  o_dato,
    output logic [TAM_MASK-1:0]  o_mascara,
    output logic                 o_is_unsigned,
    output logic                 o_valido,
    output logic                 o_desalineado,
    output logic [TAM_DATO-1:0]  o_debug_dato,
    output logic                 o_listo
);
    import memoria_datos_pkg::*;

    localparam int NB = TAM_DATO / 8;

    logic [TAM_DATO-1:0] mem [CANT_PALABRAS];

    estado_t             estado;
    logic [IDX-1:0]      cnt_limpieza;
    logic [IDX-1:0]      idx;
    logic [1:0]          offset;
    logic                desalineado;
    logic                escribe;
    logic [NB-1:0]       habilitar_byte;
    logic [TAM_DATO-1:0] dato_wr;
    logic [TAM_DATO-1:0] dato_cargado;
    logic                unused_direccion;

    // Upper address bits beyond the array simply wrap around.
    assign idx              = i_direccion[IDX+1:2];
    assign offset           = i_direccion[1:0];
    assign unused_direccion = ^i_direccion[TAM_DIREC-1:IDX+2];
    assign desalineado      = acceso_desalineado(2'(i_mascara), offset);
    assign escribe          = (estado == OPERACION) && i_habilitado && i_mem_write && !desalineado;

    // Store lanes: byte hits one lane, half hits the lane pair picked by offset[1], word hits all.
    always_comb begin
        habilitar_byte = '0;
        dato_wr        = i_dato_escritura;
        for (int b = 0; b < NB; b++) begin
            case (i_mascara)
                MASK_BYTE: habilitar_byte[b] = (b == int'(offset));
                MASK_HALF: habilitar_byte[b] = ((b / 2) == int'(offset[1]));
                default:   habilitar_byte[b] = 1'b1;
            endcase
        end
        case (i_mascara)
            MASK_BYTE: dato_wr = {NB{i_dato_escritura[7:0]}};
            MASK_HALF: dato_wr = {(NB/2){i_dato_escritura[15:0]}};
            default:   dato_wr = i_dato_escritura;
        endcase
    end

    alineador_carga #(
        .TAM_DATO (TAM_DATO),
        .TAM_MASK (TAM_MASK)
    ) u_alineador (
        .palabra (mem[idx]),
        .offset  (offset),
        .mascara (i_mascara),
        .dato    (dato_cargado)
    );

    // Array writes: zero fill while clearing, lane-masked stores while operating.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (estado == LIMPIEZA) begin
                mem[cnt_limpieza] <= '0;
            end else if (escribe) begin
                for (int b = 0; b < NB; b++) begin
                    if (habilitar_byte[b]) begin
                        mem[idx][8*b +: 8] <= dato_wr[8*b +: 8];
                    end
                end
            end
        end
    end

    // Clear/operate FSM with the registered load, flag and debug outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            estado        <= LIMPIEZA;
            cnt_limpieza  <= '0;
            o_dato        <= '0;
            o_mascara     <= '0;
            o_is_unsigned <= 1'b0;
            o_valido      <= 1'b0;
            o_desalineado <= 1'b0;
            o_debug_dato  <= '0;
            o_listo       <= 1'b0;
        end else begin
            case (estado)
                LIMPIEZA: begin
                    cnt_limpieza  <= cnt_limpieza + 1'b1;
                    o_valido      <= 1'b0;
                    o_dato        <= '0;
                    o_desalineado <= 1'b0;
                    o_debug_dato  <= '0;
                    o_listo       <= 1'b0;
                    if (cnt_limpieza == IDX'(CANT_PALABRAS - 1)) begin
                        estado <= OPERACION;
                    end
                end
                default: begin
                    o_listo      <= 1'b1;
                    o_debug_dato <= mem[i_debug_direccion];
                    if (i_habilitado) begin
                        o_mascara     <= i_mascara;
                        o_is_unsigned <= i_is_unsigned;
                        o_desalineado <= (i_mem_read || i_mem_write) && desalineado;
                        if (i_mem_read && !desalineado) begin
                            o_dato   <= dato_cargado;
                            o_valido <= 1'b1;
                        end else begin
                            o_dato   <= '0;
                            o_valido <= 1'b0;
                        end
                    end else begin
                        o_desalineado <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
